tantra_readout: RTL and testbench
=================================

# tantra_readout

Spike-count readout stage downstream of the Tantra recursive SNN core. It gates a counting window, counts output spikes per neuron with saturation, and selects the winning neuron by sequential argmax. It presents a classification result with status flags on a valid/ready handshake, converting the core's raw spike trains into a host-consumable decision.

## Interface
Parameters:
- NUM_NEURONS, 8: neurons in the core's output layer; range 2..64.
- COUNT_WIDTH, 8: per-neuron spike counter width; counters saturate.
- WINDOW_CYCLES, 64: counting window length in clocks; range 1..65535.
- IDX_W, $clog2(NUM_NEURONS): winner index width.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  one-cycle request to open a window; honoured only in IDLE.
- spikes_in  in  NUM_NEURONS  spike vector from the core's output layer.
- converged_in  in  1  core network-converged flag.
- loop_detected_in  in  1  core loop (Anavastha) flag.
- busy  out  1  high in every state except IDLE.
- result_valid  out  1  result available.
- result_ready  in  1  consumer accepts the result.
- winner_idx  out  IDX_W  index of the neuron with the highest count.
- winner_count  out  COUNT_WIDTH  count of the winning neuron.
- status  out  4  {saturated, no_spike, aborted, converged}, bit 3 down to bit 0.
- spike_counts  out  NUM_NEURONS*COUNT_WIDTH  per-neuron counts; neuron n occupies bits [n*COUNT_WIDTH +: COUNT_WIDTH].

## Operation
- FSM states are IDLE, COUNT, ARGMAX and HOLD.
- IDLE:
  - start=1 clears all counters, the window counter, the argmax registers and the status sticky bits.
  - The FSM then moves to COUNT.
- COUNT:
  - Each cycle, counter[n] increments when spikes_in[n]=1.
  - At all-ones a counter holds its value and sets the sticky status[3] (saturated).
  - The window counter increments every cycle.
  - converged_in=1 sets the sticky status[0].
  - The FSM leaves COUNT for ARGMAX on the cycle the window counter reaches WINDOW_CYCLES-1. Spikes in that cycle are counted.
  - loop_detected_in=1 in COUNT:
    - sets status[1] (aborted);
    - moves the FSM to ARGMAX immediately;
    - spikes in that same cycle are still counted.
  - When loop_detected_in and the last window cycle coincide, the window closes once and status[1] is set.
- ARGMAX:
  - One neuron is compared per cycle, index 0 through NUM_NEURONS-1.
  - Best-so-far is replaced only when count[i] is strictly greater, so on a tie the lowest index wins.
  - After index NUM_NEURONS-1 is compared, the FSM moves to HOLD.
  - If the final best count is 0, status[2] (no_spike) is set and winner_idx=0.
- HOLD:
  - result_valid=1.
  - winner_idx, winner_count, status and spike_counts hold stable until result_ready=1.
  - On result_ready=1 the FSM returns to IDLE.
  - start in the same cycle as the handshake is ignored.
- start is ignored in COUNT, ARGMAX and HOLD.
- Outputs keep their last values in IDLE until the next accepted start.
- Reset in any state:
  - returns the FSM to IDLE;
  - drives every output to 0, including busy, result_valid, winner_idx, winner_count, status and spike_counts;
  - clears all counters.

## Timing
- An accepted start at edge t gives busy=1 after t. Spikes are sampled on edges t+1 through t+WINDOW_CYCLES.
- ARGMAX occupies edges t+WINDOW_CYCLES+1 through t+WINDOW_CYCLES+NUM_NEURONS.
- result_valid=1 after edge t+WINDOW_CYCLES+NUM_NEURONS+1.
- Abort at edge a: ARGMAX starts at a+1 and result_valid rises after a+NUM_NEURONS+1.
- Minimum result_valid duration is one cycle (result_ready already high).
- busy and result_valid drop together on the handshake edge.
- The next start is accepted no earlier than the following cycle.
- spike_counts are registered. They update each COUNT cycle and are frozen from ARGMAX entry.

## Configuration
- Macro: TANTRA_READOUT_EARLY_STOP_EN.
- Defined: converged_in=1 in COUNT, held for 4 consecutive cycles, closes the window exactly like the final window cycle.
  - status[0]=1 and status[1]=0.
  - Spikes in the 4th cycle are counted.
- Undefined: converged_in only sets the sticky status[0]. The window always runs its full WINDOW_CYCLES unless aborted.

## Test plan
- Full window, defaults:
  - Stimulus: start, then spikes_in=8'b0000_0100 every cycle for 64 cycles, result_ready=1.
  - Response: result_valid after 73 edges from start, winner_idx=2, winner_count=64, status=4'b0000.
- Tie:
  - Stimulus: neurons 5 and 3 each spike 10 times.
  - Response: winner_idx=3, winner_count=10.
- No spikes:
  - Stimulus: spikes_in=0 for the whole window.
  - Response: winner_idx=0, winner_count=0, status=4'b0100.
- Saturation:
  - Stimulus: WINDOW_CYCLES=300, neuron 7 spikes every cycle.
  - Response: winner_count=255, status[3]=1.
- Abort and backpressure:
  - Stimulus: loop_detected_in pulse in window cycle 20; result_ready=0 for 5 cycles after result_valid.
  - Response: status[1]=1, counts reflect 21 cycles, outputs stable for 5 cycles, start during HOLD ignored.
- Early stop and reset:
  - Stimulus (macro defined): converged_in=1 for cycles 10..13.
  - Response: result_valid 8+1 edges after cycle 13, status=4'b0001.
  - Stimulus: rst_n=0 mid-COUNT.
  - Response: all outputs 0 on the next edge and the FSM in IDLE.

Source files
------------

// File: rtl/tantra_readout.sv
// tantra_readout: spike-count readout stage for the Tantra recursive SNN core.
// On start it opens a counting window and counts spikes per neuron, stopping
// each counter at all-ones. It then finds the winner with an argmax that
// examines one neuron per cycle. The result is presented on a valid/ready
// handshake with status {saturated, no_spike, aborted, converged}.
// Optional feature macro: TANTRA_READOUT_EARLY_STOP_EN. When it is defined,
// the window closes early once converged_in has been high for 4 consecutive
// counting cycles.
module tantra_readout #(
   parameter int NUM_NEURONS   = 8,
   parameter int COUNT_WIDTH   = 8,
   parameter int WINDOW_CYCLES = 64,
   parameter int IDX_W         = $clog2(NUM_NEURONS)
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               start,
   input  logic [NUM_NEURONS-1:0]             spikes_in,
   input  logic                               converged_in,
   input  logic                               loop_detected_in,
   output logic                               busy,
   output logic                               result_valid,
   input  logic                               result_ready,
   output logic [IDX_W-1:0]                   winner_idx,
   output logic [COUNT_WIDTH-1:0]             winner_count,
   output logic [3:0]                         status,
   output logic [NUM_NEURONS*COUNT_WIDTH-1:0] spike_counts
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_COUNT  = 2'd1,
      ST_ARGMAX = 2'd2,
      ST_HOLD   = 2'd3
   } state_t;

   localparam int                     CW_TOT   = NUM_NEURONS * COUNT_WIDTH;
   localparam logic [15:0]            WIN_LAST = 16'(WINDOW_CYCLES - 1);
   localparam logic [IDX_W-1:0]       IDX_LAST = IDX_W'(NUM_NEURONS - 1);
   localparam logic [COUNT_WIDTH-1:0] CNT_MAX  = {COUNT_WIDTH{1'b1}};
   localparam logic [COUNT_WIDTH-1:0] CNT_ZERO = {COUNT_WIDTH{1'b0}};

   state_t                   state_q,    state_d;
   logic [CW_TOT-1:0]        cnt_q,      cnt_d;
   logic [15:0]              win_q,      win_d;
   logic [IDX_W-1:0]         aidx_q,     aidx_d;
   logic [IDX_W-1:0]         best_idx_q, best_idx_d;
   logic [COUNT_WIDTH-1:0]   best_cnt_q, best_cnt_d;
   logic                     sat_q,      sat_d;
   logic                     abort_q,    abort_d;
   logic                     conv_q,     conv_d;
   logic                     busy_q,     busy_d;
   logic                     valid_q,    valid_d;
   logic [IDX_W-1:0]         widx_q,     widx_d;
   logic [COUNT_WIDTH-1:0]   wcnt_q,     wcnt_d;
   logic [3:0]               status_q,   status_d;
`ifdef TANTRA_READOUT_EARLY_STOP_EN
   logic [1:0]               conv_run_q, conv_run_d;
`endif
   logic                     close_s;
   logic [COUNT_WIDTH-1:0]   cur_s;

   // Next-state logic for the window/argmax/hold sequencer and its datapath
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      win_d      = win_q;
      aidx_d     = aidx_q;
      best_idx_d = best_idx_q;
      best_cnt_d = best_cnt_q;
      sat_d      = sat_q;
      abort_d    = abort_q;
      conv_d     = conv_q;
      busy_d     = busy_q;
      valid_d    = valid_q;
      widx_d     = widx_q;
      wcnt_d     = wcnt_q;
      status_d   = status_q;
`ifdef TANTRA_READOUT_EARLY_STOP_EN
      conv_run_d = conv_run_q;
`endif
      close_s    = 1'b0;
      cur_s      = CNT_ZERO;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d    = ST_COUNT;
               cnt_d      = {CW_TOT{1'b0}};
               win_d      = 16'd0;
               aidx_d     = {IDX_W{1'b0}};
               best_idx_d = {IDX_W{1'b0}};
               best_cnt_d = CNT_ZERO;
               sat_d      = 1'b0;
               abort_d    = 1'b0;
               conv_d     = 1'b0;
               busy_d     = 1'b1;
               valid_d    = 1'b0;
               widx_d     = {IDX_W{1'b0}};
               wcnt_d     = CNT_ZERO;
               status_d   = 4'b0000;
`ifdef TANTRA_READOUT_EARLY_STOP_EN
               conv_run_d = 2'd0;
`endif
            end else begin
               state_d = ST_IDLE;
            end
         end

         ST_COUNT: begin
            for (int n = 0; n < NUM_NEURONS; n++) begin
               if (spikes_in[n]) begin
                  if (cnt_q[n*COUNT_WIDTH +: COUNT_WIDTH] == CNT_MAX) begin
                     // counter pinned at all-ones; the lost spike is flagged
                     sat_d = 1'b1;
                  end else begin
                     cnt_d[n*COUNT_WIDTH +: COUNT_WIDTH] =
                        cnt_q[n*COUNT_WIDTH +: COUNT_WIDTH] + COUNT_WIDTH'(1);
                  end
               end else begin
                  cnt_d[n*COUNT_WIDTH +: COUNT_WIDTH] = cnt_q[n*COUNT_WIDTH +: COUNT_WIDTH];
               end
            end
            win_d   = win_q + 16'd1;
            conv_d  = conv_q | converged_in;
            abort_d = abort_q | loop_detected_in;
`ifdef TANTRA_READOUT_EARLY_STOP_EN
            // conv_run_q counts earlier consecutive converged cycles; 3 means this is the 4th
            close_s    = converged_in & (conv_run_q == 2'd3);
            conv_run_d = converged_in ? (conv_run_q + 2'd1) : 2'd0;
`endif
            close_s = close_s | (win_q == WIN_LAST) | loop_detected_in;
            if (close_s) begin
               state_d    = ST_ARGMAX;
               aidx_d     = {IDX_W{1'b0}};
               best_idx_d = {IDX_W{1'b0}};
               best_cnt_d = CNT_ZERO;
            end else begin
               state_d = ST_COUNT;
            end
         end

         ST_ARGMAX: begin
            cur_s = cnt_q[aidx_q*COUNT_WIDTH +: COUNT_WIDTH];
            // strictly greater keeps the lowest index on ties
            if (cur_s > best_cnt_q) begin
               best_cnt_d = cur_s;
               best_idx_d = aidx_q;
            end else begin
               best_cnt_d = best_cnt_q;
               best_idx_d = best_idx_q;
            end
            if (aidx_q == IDX_LAST) begin
               state_d = ST_HOLD;
            end else begin
               aidx_d = aidx_q + IDX_W'(1);
            end
         end

         ST_HOLD: begin
            if (!valid_q) begin
               // first HOLD cycle: publish the argmax result
               valid_d  = 1'b1;
               widx_d   = best_idx_q;
               wcnt_d   = best_cnt_q;
               status_d = {sat_q, (best_cnt_q == CNT_ZERO), abort_q, conv_q};
            end else if (result_ready) begin
               valid_d = 1'b0;
               busy_d  = 1'b0;
               state_d = ST_IDLE;
            end else begin
               state_d = ST_HOLD;
            end
         end

         default: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            valid_d = 1'b0;
         end
      endcase
   end

   // State and output registers, cleared by the synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         cnt_q      <= {CW_TOT{1'b0}};
         win_q      <= 16'd0;
         aidx_q     <= {IDX_W{1'b0}};
         best_idx_q <= {IDX_W{1'b0}};
         best_cnt_q <= CNT_ZERO;
         sat_q      <= 1'b0;
         abort_q    <= 1'b0;
         conv_q     <= 1'b0;
         busy_q     <= 1'b0;
         valid_q    <= 1'b0;
         widx_q     <= {IDX_W{1'b0}};
         wcnt_q     <= CNT_ZERO;
         status_q   <= 4'b0000;
`ifdef TANTRA_READOUT_EARLY_STOP_EN
         conv_run_q <= 2'd0;
`endif
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         win_q      <= win_d;
         aidx_q     <= aidx_d;
         best_idx_q <= best_idx_d;
         best_cnt_q <= best_cnt_d;
         sat_q      <= sat_d;
         abort_q    <= abort_d;
         conv_q     <= conv_d;
         busy_q     <= busy_d;
         valid_q    <= valid_d;
         widx_q     <= widx_d;
         wcnt_q     <= wcnt_d;
         status_q   <= status_d;
`ifdef TANTRA_READOUT_EARLY_STOP_EN
         conv_run_q <= conv_run_d;
`endif
      end
   end

   assign busy         = busy_q;
   assign result_valid = valid_q;
   assign winner_idx   = widx_q;
   assign winner_count = wcnt_q;
   assign status       = status_q;
   assign spike_counts = cnt_q;

endmodule

// File: tb/tb_tantra_readout.sv
// Self-checking bench for tantra_readout: random and directed windows checked
// against a plain arithmetic reference (per-neuron sums, clamp, argmax).
module tb_tantra_readout;
   localparam int N  = 8;
   localparam int CW = 8;
   localparam int W  = 64;
   localparam int SW = 300;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start, converged_in, loop_detected_in, result_ready;
   logic [N-1:0]  spikes_in;
   logic          busy, result_valid;
   logic [2:0]    winner_idx;
   logic [CW-1:0] winner_count;
   logic [3:0]    status;
   logic [N*CW-1:0] spike_counts;

   logic          s_start, s_conv, s_loop, s_ready;
   logic [N-1:0]  s_spikes;
   logic          s_busy, s_valid;
   logic [2:0]    s_widx;
   logic [CW-1:0] s_wcnt;
   logic [3:0]    s_status;
   logic [N*CW-1:0] s_counts;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   tantra_readout #(.NUM_NEURONS(N), .COUNT_WIDTH(CW), .WINDOW_CYCLES(W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .spikes_in(spikes_in),
      .converged_in(converged_in), .loop_detected_in(loop_detected_in),
      .busy(busy), .result_valid(result_valid), .result_ready(result_ready),
      .winner_idx(winner_idx), .winner_count(winner_count), .status(status),
      .spike_counts(spike_counts)
   );

   tantra_readout #(.NUM_NEURONS(N), .COUNT_WIDTH(CW), .WINDOW_CYCLES(SW)) dut_sat (
      .clk(clk), .rst_n(rst_n), .start(s_start), .spikes_in(s_spikes),
      .converged_in(s_conv), .loop_detected_in(s_loop),
      .busy(s_busy), .result_valid(s_valid), .result_ready(s_ready),
      .winner_idx(s_widx), .winner_count(s_wcnt), .status(s_status),
      .spike_counts(s_counts)
   );

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic logic [N-1:0] pattern(input int mode, input int k);
      case (mode)
         0:       return 8'b0000_0100;
         1:       return (k < 10) ? 8'b0010_1000 : 8'b0000_0000;
         2:       return 8'b0000_0000;
         default: return N'($urandom & $urandom & $urandom);
      endcase
   endfunction

   task automatic run_main(input int mode, input int abort_at, input int conv_lo,
                           input int conv_hi, input int ready_delay, input bit hold_start);
      int raw [N];
      bit sat, abrt, conv, closed;
      int k, e, c, best, best_i;
      logic [3:0] exp_st;
      logic [N*CW-1:0] exp_pack;
      logic [N-1:0] spk;
`ifdef TANTRA_READOUT_EARLY_STOP_EN
      int run = 0;
`endif
      for (int n = 0; n < N; n++) raw[n] = 0;
      sat = 1'b0; abrt = 1'b0; conv = 1'b0; closed = 1'b0; k = 0;
      start = 1'b1; result_ready = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      check("busy_after_start", busy, 1);
      while (!closed && k < W) begin
         spk = pattern(mode, k);
         spikes_in = spk;
         converged_in = (k >= conv_lo && k <= conv_hi);
         loop_detected_in = (k == abort_at);
         @(posedge clk); #1;
         for (int n = 0; n < N; n++) raw[n] += int'(spk[n]);
         if (converged_in) conv = 1'b1;
`ifdef TANTRA_READOUT_EARLY_STOP_EN
         run = converged_in ? run + 1 : 0;
         if (run == 4) closed = 1'b1;
`endif
         if (loop_detected_in) begin
            abrt = 1'b1;
            closed = 1'b1;
         end
         if (k == W-1) closed = 1'b1;
         k++;
      end
      spikes_in = '0; converged_in = 1'b0; loop_detected_in = 1'b0;

      best = 0; best_i = 0; exp_pack = '0;
      for (int n = 0; n < N; n++) begin
         c = (raw[n] > 255) ? 255 : raw[n];
         if (raw[n] > 255) sat = 1'b1;
         exp_pack[n*CW +: CW] = CW'(c);
         if (c > best) begin
            best = c;
            best_i = n;
         end
      end
      exp_st = {sat, (best == 0), abrt, conv};
      check("counts_at_close", spike_counts, exp_pack);

      result_ready = (ready_delay == 0);
      e = 0;
      while (e < N + 10) begin
         spikes_in = N'($urandom);
         @(posedge clk); #1;
         e++;
         if (result_valid) break;
      end
      spikes_in = '0;
      check("latency", e, N + 1);
      check("winner_idx", winner_idx, best_i);
      check("winner_count", winner_count, best);
      check("status", status, exp_st);
      check("counts_frozen", spike_counts, exp_pack);
      check("busy_hold", busy, 1);

      for (int d = 0; d < ready_delay; d++) begin
         start = hold_start;
         @(posedge clk); #1;
         check("bp_valid", result_valid, 1);
         check("bp_idx", winner_idx, best_i);
         check("bp_count", winner_count, best);
         check("bp_status", status, exp_st);
      end
      result_ready = 1'b1;
      start = hold_start;
      @(posedge clk); #1;
      start = 1'b0; result_ready = 1'b0;
      check("hs_valid", result_valid, 0);
      check("hs_busy", busy, 0);
      @(posedge clk); #1;
      check("idle_busy", busy, 0);
      check("idle_count", winner_count, best);
      check("idle_status", status, exp_st);
      check("idle_counts", spike_counts, exp_pack);
   endtask

   initial begin
      int e, lo, hi, ab;
      logic [N*CW-1:0] sat_pack;
      rst_n = 1'b0; start = 1'b0; spikes_in = '0; converged_in = 1'b0;
      loop_detected_in = 1'b0; result_ready = 1'b0;
      s_start = 1'b0; s_spikes = '0; s_conv = 1'b0; s_loop = 1'b0; s_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_busy", busy, 0);
      check("reset_valid", result_valid, 0);
      check("reset_counts", spike_counts, 0);
      check("reset_status", status, 0);
      check("reset_sat_busy", s_busy, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      run_main(0, -1, -1, -1, 0, 1'b0);   // full window, neuron 2 always
      run_main(1, -1, -1, -1, 0, 1'b0);   // tie between 3 and 5
      run_main(2, -1, -1, -1, 0, 1'b0);   // no spikes
      run_main(3, 20, -1, -1, 5, 1'b1);   // abort + backpressure + start in HOLD
      run_main(0, -1, 10, 13, 0, 1'b0);   // converged for 4 cycles
      run_main(3, W-1, -1, -1, 1, 1'b0);  // abort on the last window cycle
      for (int i = 0; i < 4; i++) begin
         ab = ($urandom_range(1, 0) == 1) ? int'($urandom_range(W-1, 0)) : -1;
         lo = int'($urandom_range(W-1, 0));
         hi = lo + int'($urandom_range(6, 0));
         run_main(3, ab, lo, hi, int'($urandom_range(3, 0)), 1'b1);
      end

      // reset in the middle of a counting window
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int k = 0; k < 30; k++) begin
         spikes_in = 8'hFF;
         @(posedge clk); #1;
      end
      rst_n = 1'b0;
      @(posedge clk); #1;
      check("rst_busy", busy, 0);
      check("rst_valid", result_valid, 0);
      check("rst_idx", winner_idx, 0);
      check("rst_count", winner_count, 0);
      check("rst_status", status, 0);
      check("rst_counts", spike_counts, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("rst_idle_busy", busy, 0);
      check("rst_idle_counts", spike_counts, 0);
      spikes_in = '0;
      run_main(3, -1, -1, -1, 0, 1'b0);

      // saturation on the long-window instance
      s_start = 1'b1;
      @(posedge clk); #1;
      s_start = 1'b0;
      for (int k = 0; k < SW; k++) begin
         s_spikes = 8'h80;
         @(posedge clk); #1;
      end
      s_spikes = '0;
      s_ready = 1'b1;
      e = 0;
      while (e < N + 10) begin
         @(posedge clk); #1;
         e++;
         if (s_valid) break;
      end
      sat_pack = {8'hFF, 56'h0};
      check("sat_latency", e, N + 1);
      check("sat_count", s_wcnt, 255);
      check("sat_idx", s_widx, 7);
      check("sat_status", s_status, 4'b1000);
      check("sat_counts", s_counts, sat_pack);
      @(posedge clk); #1;
      s_ready = 1'b0;
      check("sat_hs_valid", s_valid, 0);
      check("sat_hs_busy", s_busy, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
